// File: rtl/qspi_ram_target_if.sv
// Quad-SPI pin bundle between the memory-controller master and the RAM target.
interface qspi_ram_target_if;
  logic       spi_clk_in;
  logic       spi_select;
  logic [3:0] spi_data_in;
  logic [3:0] spi_data_out;
  logic [3:0] spi_data_oe;
  logic       busy;
  logic       cmd_error;

  modport master (
    output spi_clk_in, spi_select, spi_data_in,
    input  spi_data_out, spi_data_oe, busy, cmd_error
  );

  modport slave (
    input  spi_clk_in, spi_select, spi_data_in,
    output spi_data_out, spi_data_oe, busy, cmd_error
  );
endinterface

// File: rtl/qspi_ram_target.sv
// Quad-SPI RAM responder. Oversamples the SPI pins on the system clock and
// serves quad write (0x38) and quad fast read (0xEB) from an on-chip byte array.
// The array has no reset so its contents survive a reset pulse.
module qspi_ram_target #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int MEM_DEPTH     = 256,
  parameter int DUMMY_CYCLES  = 6
) (
  input logic              clock,
  input logic              reset,
  qspi_ram_target_if.slave bus
);
  localparam int MEM_AW       = $clog2(MEM_DEPTH);
  localparam int ADDR_NIBBLES = ADDRESS_WIDTH / 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    READ   = 3'd4,
    WRITE  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  // synchroniser and edge detect
  logic [1:0]               sclk_sync_r;
  logic [1:0]               sel_sync_r;
  logic [3:0]               data_meta_r;
  logic [3:0]               data_sync_r;
  logic                     sclk_prev_r;
  logic                     sclk_rise_s;
  logic                     sclk_fall_s;
  logic                     sel_s;
  logic [3:0]               nib_s;

  // protocol state
  state_t                   state_r;
  logic [7:0]               cnt_r;
  logic [3:0]               cmd_hi_r;
  logic                     is_read_r;
  logic [ADDRESS_WIDTH-1:0] addr_r;
  logic [7:0]               shift_r;
  logic                     nib_hi_r;
  logic                     wr_phase_r;
  logic [3:0]               wr_hi_r;
  logic                     wr_en_r;
  logic [MEM_AW-1:0]        wr_addr_r;
  logic [7:0]               wr_data_r;
  logic [3:0]               data_out_r;
  logic [3:0]               oe_r;
  logic                     busy_r;
  logic                     cmd_error_r;

  logic [7:0]               cmd_next_s;
  logic [ADDRESS_WIDTH-1:0] addr_next_s;
  logic [ADDRESS_WIDTH-1:0] addr_inc_s;

  logic [7:0]               mem_r [MEM_DEPTH];

  // Data is synchronised with the same latency as sclk, so it lines up with the detected edge.
  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_r[1] & sclk_prev_r;
  assign sel_s       = sel_sync_r[1];
  assign nib_s       = data_sync_r;
  assign cmd_next_s  = {cmd_hi_r, nib_s};
  assign addr_next_s = {addr_r[ADDRESS_WIDTH-5:0], nib_s};
  assign addr_inc_s  = addr_r + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  assign bus.spi_data_out = data_out_r;
  assign bus.spi_data_oe  = oe_r;
  assign bus.busy         = busy_r;
  assign bus.cmd_error    = cmd_error_r;

  // Two-flop synchronisers on all SPI inputs plus the sclk history flop for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sync_r <= 2'b00;
      sel_sync_r  <= 2'b11;
      data_meta_r <= 4'h0;
      data_sync_r <= 4'h0;
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], bus.spi_clk_in};
      sel_sync_r  <= {sel_sync_r[0], bus.spi_select};
      data_meta_r <= bus.spi_data_in;
      data_sync_r <= data_meta_r;
      sclk_prev_r <= sclk_sync_r[1];
    end
  end

  // Protocol FSM: decodes command and address, shifts read data out, posts byte writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      cmd_hi_r    <= 4'h0;
      is_read_r   <= 1'b0;
      addr_r      <= '0;
      shift_r     <= 8'h00;
      nib_hi_r    <= 1'b1;
      wr_phase_r  <= 1'b0;
      wr_hi_r     <= 4'h0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= 8'h00;
      data_out_r  <= 4'h0;
      oe_r        <= 4'h0;
      busy_r      <= 1'b0;
      cmd_error_r <= 1'b0;
    end else begin
      cmd_error_r <= 1'b0;
      wr_en_r     <= 1'b0;
      if (sel_s) begin
        // deselect aborts anything in flight, including a half-received write byte
        state_r    <= IDLE;
        cnt_r      <= 8'd0;
        wr_phase_r <= 1'b0;
        oe_r       <= 4'h0;
        busy_r     <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= CMD;
            cnt_r   <= 8'd0;
            busy_r  <= 1'b1;
          end
          CMD: begin
            if (sclk_rise_s) begin
              cmd_hi_r <= nib_s;
              if (cnt_r == 8'd0) begin
                cnt_r <= 8'd1;
              end else begin
                cnt_r <= 8'd0;
                case (cmd_next_s)
                  8'h38: begin
                    state_r   <= ADDR;
                    is_read_r <= 1'b0;
                  end
                  8'hEB: begin
                    state_r   <= ADDR;
                    is_read_r <= 1'b1;
                  end
                  default: begin
                    state_r     <= IGNORE;
                    cmd_error_r <= 1'b1;
                  end
                endcase
              end
            end
          end
          ADDR: begin
            if (sclk_rise_s) begin
              addr_r <= addr_next_s;
              if (cnt_r == 8'(ADDR_NIBBLES - 1)) begin
                cnt_r <= 8'd0;
                if (!is_read_r) begin
                  state_r    <= WRITE;
                  wr_phase_r <= 1'b0;
                end else if (DUMMY_CYCLES == 0) begin
                  state_r  <= READ;
                  shift_r  <= mem_r[addr_next_s[MEM_AW-1:0]];
                  nib_hi_r <= 1'b1;
                end else begin
                  state_r <= DUMMY;
                end
              end else begin
                cnt_r <= cnt_r + 8'd1;
              end
            end
          end
          DUMMY: begin
            if (sclk_rise_s) begin
              if (cnt_r == 8'(DUMMY_CYCLES - 1)) begin
                cnt_r    <= 8'd0;
                state_r  <= READ;
                shift_r  <= mem_r[addr_r[MEM_AW-1:0]];
                nib_hi_r <= 1'b1;
              end else begin
                cnt_r <= cnt_r + 8'd1;
              end
            end
          end
          READ: begin
            if (sclk_fall_s) begin
              oe_r       <= 4'hF;
              data_out_r <= nib_hi_r ? shift_r[7:4] : shift_r[3:0];
              nib_hi_r   <= ~nib_hi_r;
            end else if (sclk_rise_s && nib_hi_r) begin
              // low nibble just consumed: prefetch the next byte
              addr_r  <= addr_inc_s;
              shift_r <= mem_r[addr_inc_s[MEM_AW-1:0]];
            end
          end
          WRITE: begin
            if (sclk_rise_s) begin
              if (!wr_phase_r) begin
                wr_hi_r    <= nib_s;
                wr_phase_r <= 1'b1;
              end else begin
                wr_en_r    <= 1'b1;
                wr_addr_r  <= addr_r[MEM_AW-1:0];
                wr_data_r  <= {wr_hi_r, nib_s};
                addr_r     <= addr_inc_s;
                wr_phase_r <= 1'b0;
              end
            end
          end
          IGNORE: begin
            oe_r <= 4'h0;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  // Storage array: commits posted byte writes; intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_en_r) begin
      mem_r[wr_addr_r] <= wr_data_r;
    end
  end
endmodule

// File: tb/tb_qspi_ram_target.sv
// Directed bench for qspi_ram_target: plays the QSPI master with a slow sclk
// (6 system clocks per phase) and checks against hand-computed values.
module tb_qspi_ram_target;
  logic clock;
  logic reset;
  int   n_vec;
  int   n_bad;
  int   err_cnt;
  int   err_base;
  logic [3:0] q;
  logic [3:0] oe;
  logic [3:0] oe_acc;

  qspi_ram_target_if bus ();

  qspi_ram_target #(
    .ADDRESS_WIDTH(16),
    .MEM_DEPTH(256),
    .DUMMY_CYCLES(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // system clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // count cycles on which cmd_error is high
  always @(negedge clock) begin
    if (bus.cmd_error === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one sclk period: drive nibble after the fall, sample target output just before the rise
  task automatic sclk_cycle(input logic [3:0] d, output logic [3:0] qo, output logic [3:0] oeo);
    bus.spi_data_in = d;
    repeat (6) @(negedge clock);
    qo  = bus.spi_data_out;
    oeo = bus.spi_data_oe;
    oe_acc = oe_acc | oeo;
    bus.spi_clk_in = 1'b1;
    repeat (6) @(negedge clock);
    bus.spi_clk_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] qx;
    logic [3:0] ox;
    sclk_cycle(b[7:4], qx, ox);
    sclk_cycle(b[3:0], qx, ox);
  endtask

  task automatic sel_low();
    bus.spi_select = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic sel_high();
    bus.spi_select = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic write2(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1);
    sel_low();
    send_byte(8'h38);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(b0);
    send_byte(b1);
    sel_high();
  endtask

  task automatic read_hdr(input logic [15:0] a);
    logic [3:0] qx;
    logic [3:0] ox;
    sel_low();
    send_byte(8'hEB);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    for (int i = 0; i < 6; i++) sclk_cycle(4'h0, qx, ox);
  endtask

  // full read of n nibbles, each compared with exp (MSB nibble first) and oe=F
  task automatic read_chk(input string tag, input logic [15:0] a, input int n, input logic [15:0] exp);
    logic [15:0] e;
    e = exp;
    read_hdr(a);
    for (int i = 0; i < n; i++) begin
      sclk_cycle(4'h0, q, oe);
      chk($sformatf("%s_nib%0d", tag, i), {28'h0, q}, {28'h0, e[15:12]});
      chk($sformatf("%s_oe%0d", tag, i), {28'h0, oe}, 32'h0000000F);
      e = {e[11:0], 4'h0};
    end
    sel_high();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    err_cnt = 0;
    oe_acc = 4'h0;
    reset = 1'b1;
    bus.spi_clk_in = 1'b0;
    bus.spi_select = 1'b1;
    bus.spi_data_in = 4'h0;
    repeat (4) @(negedge clock);
    chk("rst_dout", {28'h0, bus.spi_data_out}, 32'h0);
    chk("rst_oe", {28'h0, bus.spi_data_oe}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_err", {31'h0, bus.cmd_error}, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // 1: write A5,3C at 0x0010, target stays off the bus
    oe_acc = 4'h0;
    sel_low();
    chk("t1_busy", {31'h0, bus.busy}, 32'h1);
    send_byte(8'h38);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'hA5);
    send_byte(8'h3C);
    sel_high();
    chk("t1_busy_off", {31'h0, bus.busy}, 32'h0);
    chk("t1_oe", {28'h0, oe_acc}, 32'h0);

    // 2: read back with dummy phase quiet
    oe_acc = 4'h0;
    read_hdr(16'h0010);
    chk("t2_dummy_oe", {28'h0, oe_acc}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      sclk_cycle(4'h0, q, oe);
      chk($sformatf("t2_nib%0d", i), {28'h0, q}, (i == 0) ? 32'hA : (i == 1) ? 32'h5 : (i == 2) ? 32'h3 : 32'hC);
      chk($sformatf("t2_oe%0d", i), {28'h0, oe}, 32'hF);
    end
    sel_high();
    chk("t2_oe_off", {28'h0, bus.spi_data_oe}, 32'h0);

    // 3: write across the wrap point and read it back
    write2(16'h00FF, 8'h11, 8'h22);
    read_chk("t3", 16'h00FF, 4, 16'h1122);
    read_chk("t3b", 16'h0000, 2, 16'h2200);

    // 4: unsupported command, then a stream that would look like a write if decoded
    err_base = err_cnt;
    oe_acc = 4'h0;
    sel_low();
    send_byte(8'h9F);
    chk("t4_err_pulse", err_cnt - err_base, 32'd1);
    send_byte(8'h38);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("t4_oe", {28'h0, oe_acc}, 32'h0);
    chk("t4_err_once", err_cnt - err_base, 32'd1);
    chk("t4_busy", {31'h0, bus.busy}, 32'h1);
    sel_high();
    chk("t4_busy_off", {31'h0, bus.busy}, 32'h0);
    read_chk("t4_mem", 16'h0010, 4, 16'hA53C);

    // 5: half a byte then deselect leaves memory unchanged
    write2(16'h0020, 8'h5A, 8'h00);
    sel_low();
    send_byte(8'h38);
    send_byte(8'h00);
    send_byte(8'h20);
    sclk_cycle(4'h7, q, oe);
    sel_high();
    read_chk("t5", 16'h0020, 4, 16'h5A00);

    // 6: reset in the middle of read data
    read_hdr(16'h00FF);
    sclk_cycle(4'h0, q, oe);
    chk("t6_pre_nib", {28'h0, q}, 32'h1);
    sclk_cycle(4'h0, q, oe);
    chk("t6_pre_oe", {28'h0, bus.spi_data_oe}, 32'hF);
    reset = 1'b1;
    #1;
    chk("t6_oe", {28'h0, bus.spi_data_oe}, 32'h0);
    chk("t6_busy", {31'h0, bus.busy}, 32'h0);
    chk("t6_dout", {28'h0, bus.spi_data_out}, 32'h0);
    bus.spi_select = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    read_chk("t6_mem", 16'h0010, 4, 16'hA53C);
    read_chk("t6_wrap", 16'h00FF, 4, 16'h1122);

    chk("err_total", err_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
